attack_issuer: RTL and testbench
================================

Name: attack_issuer

Overview:
- Initiator side of the attack interface: turns player button input into the coordinate codes and active-low confirm strobe that the attack-round logic consumes, then reads back that logic's hit indication.
- Holds a cursor over the 5x7 board, blocks repeat shots, counts shots and hits, and declares the game over (win or loss).
- Sits between the board-level button inputs and the attack-round block; its outputs also drive the scoreboard display.

Parameters:
- COLUNE_SIZE, 7, rows per column (y range).
- TOTAL_COLUNES, 5, columns (x range).
- MAX_SHOTS, 15, shots per game; width of shots_left = 4.
- SHIP_CELLS, 9, hits needed to win; width of hits_count = 4.
- RESULT_WAIT, 2, cycles between releasing the confirm strobe and sampling hit_in (1..7).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- btn_left, btn_right, btn_up, btn_down  input  1 each  synchronous, already-debounced levels; active high
- btn_fire  input  1  synchronous, already-debounced level; active high
- new_game  input  1  synchronous clear of game state; active high
- hit_in  input  1  hit indication from the attack-round block (1 = ship at addressed cell)
- x_coord_code  output  3  column code, valid range 1..5
- y_coord_code  output  3  row code, valid range 1..7
- confirm_attack  output  1  active-low fire strobe to the attack-round block
- shot_valid  output  1  one-cycle pulse when a shot result is recorded
- shot_hit  output  1  result of the last recorded shot, held
- dup_shot  output  1  one-cycle pulse when fire is rejected because the cell was already shot
- shots_left  output  4  remaining shots
- hits_count  output  4  hits so far
- game_over  output  1  high once the game has ended
- win  output  1  high with game_over when hits_count reached SHIP_CELLS

Behaviour:
- Reset (asynchronous, active low) drives:
  - x_coord_code = 1, y_coord_code = 1, confirm_attack = 1;
  - shot_valid = 0, shot_hit = 0, dup_shot = 0;
  - shots_left = MAX_SHOTS, hits_count = 0, game_over = 0, win = 0;
  - 35-bit shot map cleared; state = IDLE.
- Edge detection: every button is registered once; an action happens on the 0->1 edge only. Holding a button never auto-repeats.
- Cursor (IDLE state only):
  - right: x+1, wrapping 5->1; left: x-1, wrapping 1->5.
  - up: y+1, wrapping 7->1; down: y-1, wrapping 1->7.
  - Simultaneous edges: left and right together cancel; up and down together cancel; one x move and one y move together both apply.
  - Codes 0, 6 and 7 are never produced.
  - Moves are ignored in FIRE, WAIT, EVAL and OVER.
- Shot map index = (x_code-1)*COLUNE_SIZE + (y_code-1).
- FSM states: IDLE, FIRE, WAIT, EVAL, OVER.
  - IDLE, fire edge, map bit set: dup_shot pulses for 1 cycle; stay in IDLE; no other change.
  - IDLE, fire edge, map bit clear: go to FIRE. confirm_attack = 0 for exactly 1 cycle. The map bit is set on that cycle.
  - Fire edge together with a move edge: the fire is processed at the pre-move cursor, and the move is dropped.
  - FIRE -> WAIT: confirm_attack returns to 1; the WAIT counter loads RESULT_WAIT-1.
  - WAIT: counts down to 0, then goes to EVAL. Total latency from the confirm low cycle to the EVAL cycle is RESULT_WAIT+1 cycles.
  - EVAL:
    - hit_in is sampled and held in shot_hit; shot_valid pulses for 1 cycle.
    - shots_left decrements (saturates at 0); hits_count increments on a hit (saturates at SHIP_CELLS).
    - Next state is OVER if the new hits_count = SHIP_CELLS (win=1) or the new shots_left = 0 (win=0); otherwise IDLE.
    - A win on the last shot counts as a win.
  - OVER: game_over = 1. All buttons are ignored; the cursor and counters are frozen.
- Coordinates are stable from the FIRE cycle through EVAL.
- new_game: in any state it synchronously forces every output and register to its reset value on the next edge. It has priority over every other event, including a fire in the same cycle and the middle of a FIRE/WAIT sequence; confirm_attack returns to 1 immediately.
- Asynchronous reset during FIRE or WAIT aborts the shot. The map and counters are cleared and no shot_valid is issued.

Decomposition:
- Shared package holds:
  - localparams X_MIN=1, X_MAX=TOTAL_COLUNES, Y_MIN=1, Y_MAX=COLUNE_SIZE;
  - the FSM state encoding (3-bit: IDLE, FIRE, WAIT, EVAL, OVER);
  - the cell-index function.
- One sub-module, cursor_wrap_counter: a 3-bit up/down counter with configurable min/max wrap and enable. Instantiated twice, once for x and once for y.

Test Plan:
- Reset, then 5 right edges -> x_coord_code sequence 2,3,4,5,1. After one down edge from y=1 -> y_coord_code = 7.
- Cursor (3,4), fire with hit_in=1, RESULT_WAIT=2 -> confirm_attack low for 1 cycle. EVAL occurs 3 cycles after the low cycle: shot_valid=1, shot_hit=1, hits_count=1, shots_left=14.
- Fire again at (3,4) -> dup_shot pulses once, confirm_attack stays 1, counters unchanged.
- 15 distinct misses -> after the 15th EVAL: shots_left=0, game_over=1, win=0. Further fire or move edges produce no change.
- 9 distinct hits -> game_over=1, win=1, hits_count=9, shots_left=6.
- new_game asserted during WAIT -> confirm_attack=1, no shot_valid, counters back to reset values. Asynchronous reset pulse during FIRE -> same result.

Source files
------------

// File: rtl/attack_issuer_pkg.sv
// Shared board geometry, game limits, FSM encoding and the cell-index helper
// for the attack issuer.
package attack_issuer_pkg;

  localparam int COLUNE_SIZE   = 7;
  localparam int TOTAL_COLUNES = 5;
  localparam int MAX_SHOTS     = 15;
  localparam int SHIP_CELLS    = 9;
  localparam int RESULT_WAIT   = 2;
  localparam int CELLS         = COLUNE_SIZE * TOTAL_COLUNES;

  localparam logic [2:0] X_MIN = 3'd1;
  localparam logic [2:0] X_MAX = 3'(TOTAL_COLUNES);
  localparam logic [2:0] Y_MIN = 3'd1;
  localparam logic [2:0] Y_MAX = 3'(COLUNE_SIZE);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FIRE = 3'd1,
    WAIT = 3'd2,
    EVAL = 3'd3,
    OVER = 3'd4
  } state_t;

  // Codes are 1-based, so both are shifted down before being packed column-major.
  function automatic logic [5:0] cell_index(input logic [2:0] x, input logic [2:0] y);
    return 6'((int'(x) - 1) * COLUNE_SIZE + (int'(y) - 1));
  endfunction

endpackage

// File: rtl/attack_issuer_cursor_wrap_counter.sv
// 3-bit up/down cursor counter that wraps between MIN and MAX; opposing
// requests in the same cycle cancel.
module cursor_wrap_counter #(
  parameter logic [2:0] MIN = 3'd1,
  parameter logic [2:0] MAX = 3'd7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic       inc,
  input  logic       dec,
  output logic [2:0] value
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= MIN;
    end else if (clear) begin
      value <= MIN;
    end else if (en && inc && !dec) begin
      value <= (value == MAX) ? MIN : value + 3'd1;
    end else if (en && dec && !inc) begin
      value <= (value == MIN) ? MAX : value - 3'd1;
    end
  end

endmodule

// File: rtl/attack_issuer.sv
// Initiator side of the attack interface: cursor, fire strobe, result capture,
// repeat-shot blocking and win/loss bookkeeping.
module attack_issuer
  import attack_issuer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_fire,
  input  logic       new_game,
  input  logic       hit_in,
  output logic [2:0] x_coord_code,
  output logic [2:0] y_coord_code,
  output logic       confirm_attack,
  output logic       shot_valid,
  output logic       shot_hit,
  output logic       dup_shot,
  output logic [3:0] shots_left,
  output logic [3:0] hits_count,
  output logic       game_over,
  output logic       win
);

  state_t           state;
  state_t           state_next;
  logic [4:0]       btn_now;
  logic [4:0]       btn_q;
  logic [4:0]       btn_edge;
  logic [CELLS-1:0] shot_map;
  logic [2:0]       wait_cnt;
  logic [5:0]       idx;
  logic             fire_edge;
  logic             fire_ok;
  logic             fire_dup;
  logic             move_en;
  logic             result_now;

  // Bit order: fire, left, right, up, down.
  assign btn_now    = {btn_fire, btn_left, btn_right, btn_up, btn_down};
  assign btn_edge   = btn_now & ~btn_q;
  assign fire_edge  = btn_edge[4];
  assign idx        = cell_index(x_coord_code, y_coord_code);
  assign fire_dup   = (state == IDLE) && fire_edge && shot_map[idx];
  assign fire_ok    = (state == IDLE) && fire_edge && !shot_map[idx];
  assign move_en    = (state == IDLE) && !fire_edge;
  assign result_now = (state == WAIT) && (wait_cnt == 3'd0);

  cursor_wrap_counter #(.MIN(X_MIN), .MAX(X_MAX)) u_x_cursor (
    .clk   (clk),
    .reset (reset),
    .clear (new_game),
    .en    (move_en),
    .inc   (btn_edge[2]),
    .dec   (btn_edge[3]),
    .value (x_coord_code)
  );

  cursor_wrap_counter #(.MIN(Y_MIN), .MAX(Y_MAX)) u_y_cursor (
    .clk   (clk),
    .reset (reset),
    .clear (new_game),
    .en    (move_en),
    .inc   (btn_edge[1]),
    .dec   (btn_edge[0]),
    .value (y_coord_code)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else if (new_game) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Counters are already updated while in EVAL, so the game-end decision reads them directly.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (fire_ok) state_next = FIRE;
      FIRE:    state_next = WAIT;
      WAIT:    if (wait_cnt == 3'd0) state_next = EVAL;
      EVAL:    if (hits_count == 4'(SHIP_CELLS) || shots_left == 4'd0) state_next = OVER;
               else state_next = IDLE;
      OVER:    state_next = OVER;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    confirm_attack = (state != FIRE);
    game_over      = (state == OVER);
    win            = (state == OVER) && (hits_count == 4'(SHIP_CELLS));
  end

  // The result is captured as EVAL is entered, RESULT_WAIT cycles after confirm is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_q      <= '0;
      shot_map   <= '0;
      wait_cnt   <= '0;
      shot_valid <= 1'b0;
      shot_hit   <= 1'b0;
      dup_shot   <= 1'b0;
      shots_left <= 4'(MAX_SHOTS);
      hits_count <= '0;
    end else if (new_game) begin
      btn_q      <= '0;
      shot_map   <= '0;
      wait_cnt   <= '0;
      shot_valid <= 1'b0;
      shot_hit   <= 1'b0;
      dup_shot   <= 1'b0;
      shots_left <= 4'(MAX_SHOTS);
      hits_count <= '0;
    end else begin
      btn_q      <= btn_now;
      shot_valid <= result_now;
      dup_shot   <= fire_dup;
      if (fire_ok) begin
        shot_map[idx] <= 1'b1;
      end
      if (state == FIRE) begin
        wait_cnt <= 3'(RESULT_WAIT - 1);
      end else if (state == WAIT && wait_cnt != 3'd0) begin
        wait_cnt <= wait_cnt - 3'd1;
      end
      if (result_now) begin
        shot_hit   <= hit_in;
        shots_left <= (shots_left == 4'd0) ? 4'd0 : shots_left - 4'd1;
        if (hit_in && hits_count != 4'(SHIP_CELLS)) begin
          hits_count <= hits_count + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_attack_issuer.sv
// Self-checking bench for attack_issuer: a cursor vector table, hand-written
// shot/abort sequences and randomized games against a transaction-level model.
module tb_attack_issuer;
  import attack_issuer_pkg::*;

  logic       clk;
  logic       reset;
  logic       btn_left, btn_right, btn_up, btn_down, btn_fire;
  logic       new_game;
  logic       hit_in;
  logic [2:0] x_coord_code, y_coord_code;
  logic       confirm_attack, shot_valid, shot_hit, dup_shot;
  logic [3:0] shots_left, hits_count;
  logic       game_over, win;

  int checks   = 0;
  int failures = 0;

  // Model: cursor, shot set and score kept as plain integers per transaction.
  int mx, my, m_shots, m_hits;
  bit m_over;
  bit m_map[CELLS];

  typedef struct {
    int l, r, u, d;
    int ex, ey;
  } move_vec_t;

  move_vec_t vecs[18];

  attack_issuer dut (
    .clk            (clk),
    .reset          (reset),
    .btn_left       (btn_left),
    .btn_right      (btn_right),
    .btn_up         (btn_up),
    .btn_down       (btn_down),
    .btn_fire       (btn_fire),
    .new_game       (new_game),
    .hit_in         (hit_in),
    .x_coord_code   (x_coord_code),
    .y_coord_code   (y_coord_code),
    .confirm_attack (confirm_attack),
    .shot_valid     (shot_valid),
    .shot_hit       (shot_hit),
    .dup_shot       (dup_shot),
    .shots_left     (shots_left),
    .hits_count     (hits_count),
    .game_over      (game_over),
    .win            (win)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input int expected);
    checks++;
    if (actual !== 32'(expected)) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input int l, input int r, input int u, input int d, input int f);
    btn_left  = 1'(l);
    btn_right = 1'(r);
    btn_up    = 1'(u);
    btn_down  = 1'(d);
    btn_fire  = 1'(f);
  endtask

  function automatic void model_reset();
    mx = 1;
    my = 1;
    m_shots = MAX_SHOTS;
    m_hits = 0;
    m_over = 1'b0;
    foreach (m_map[i]) m_map[i] = 1'b0;
  endfunction

  function automatic int wrap(input int v, input int delta, input int n);
    return ((v - 1 + delta + n) % n) + 1;
  endfunction

  task automatic check_state(input string tag);
    check_output({tag, ".x"}, 32'(x_coord_code), mx);
    check_output({tag, ".y"}, 32'(y_coord_code), my);
    check_output({tag, ".shots_left"}, 32'(shots_left), m_shots);
    check_output({tag, ".hits_count"}, 32'(hits_count), m_hits);
    check_output({tag, ".game_over"}, 32'(game_over), int'(m_over));
    check_output({tag, ".win"}, 32'(win), int'(m_over && m_hits == SHIP_CELLS));
  endtask

  task automatic op_move(input int l, input int r, input int u, input int d, input string tag);
    apply_stimulus(l, r, u, d, 0);
    tick();
    if (!m_over) begin
      mx = wrap(mx, r - l, TOTAL_COLUNES);
      my = wrap(my, u - d, COLUNE_SIZE);
    end
    check_output({tag, ".confirm"}, 32'(confirm_attack), 1);
    check_output({tag, ".dup"}, 32'(dup_shot), 0);
    apply_stimulus(0, 0, 0, 0, 0);
    tick();
    check_state(tag);
  endtask

  // Fire (optionally with move edges, which must be dropped) and follow the shot to completion.
  task automatic op_fire(input int l, input int r, input int u, input int d, input int hit, input string tag);
    int idx;
    idx = (mx - 1) * COLUNE_SIZE + (my - 1);
    apply_stimulus(l, r, u, d, 1);
    tick();
    if (m_over) begin
      apply_stimulus(0, 0, 0, 0, 0);
      hit_in = 1'(hit);
      for (int i = 0; i < 5; i++) begin
        check_output({tag, ".over_confirm"}, 32'(confirm_attack), 1);
        check_output({tag, ".over_valid"}, 32'(shot_valid), 0);
        tick();
      end
      check_state({tag, ".over"});
    end else if (m_map[idx]) begin
      check_output({tag, ".dup_pulse"}, 32'(dup_shot), 1);
      check_output({tag, ".dup_confirm"}, 32'(confirm_attack), 1);
      apply_stimulus(0, 0, 0, 0, 0);
      tick();
      check_output({tag, ".dup_end"}, 32'(dup_shot), 0);
      check_state({tag, ".dup"});
    end else begin
      m_map[idx] = 1'b1;
      check_output({tag, ".confirm_low"}, 32'(confirm_attack), 0);
      check_output({tag, ".fire_valid"}, 32'(shot_valid), 0);
      apply_stimulus(0, 0, 0, 0, 0);
      hit_in = 1'(hit);
      tick();
      check_output({tag, ".confirm_release"}, 32'(confirm_attack), 1);
      tick();
      check_output({tag, ".early_valid"}, 32'(shot_valid), 0);
      check_output({tag, ".hold_x"}, 32'(x_coord_code), mx);
      check_output({tag, ".hold_y"}, 32'(y_coord_code), my);
      tick();
      m_shots = m_shots - 1;
      if (hit != 0) m_hits = m_hits + 1;
      check_output({tag, ".eval_valid"}, 32'(shot_valid), 1);
      check_output({tag, ".eval_hit"}, 32'(shot_hit), hit);
      check_output({tag, ".eval_shots"}, 32'(shots_left), m_shots);
      check_output({tag, ".eval_hits"}, 32'(hits_count), m_hits);
      if (m_hits == SHIP_CELLS || m_shots == 0) m_over = 1'b1;
      tick();
      check_output({tag, ".valid_end"}, 32'(shot_valid), 0);
      check_output({tag, ".hit_held"}, 32'(shot_hit), hit);
      check_state({tag, ".after"});
    end
  endtask

  task automatic op_new_game(input string tag);
    new_game = 1'b1;
    tick();
    model_reset();
    check_state(tag);
    check_output({tag, ".confirm"}, 32'(confirm_attack), 1);
    check_output({tag, ".valid"}, 32'(shot_valid), 0);
    new_game = 1'b0;
    tick();
  endtask

  task automatic check_no_result(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check_output({tag, ".no_valid"}, 32'(shot_valid), 0);
      check_output({tag, ".confirm"}, 32'(confirm_attack), 1);
      tick();
    end
  endtask

  initial begin
    vecs[0]  = '{0, 1, 0, 0, 2, 1};
    vecs[1]  = '{0, 1, 0, 0, 3, 1};
    vecs[2]  = '{0, 1, 0, 0, 4, 1};
    vecs[3]  = '{0, 1, 0, 0, 5, 1};
    vecs[4]  = '{0, 1, 0, 0, 1, 1};
    vecs[5]  = '{0, 0, 0, 1, 1, 7};
    vecs[6]  = '{0, 0, 1, 0, 1, 1};
    vecs[7]  = '{1, 0, 0, 0, 5, 1};
    vecs[8]  = '{1, 1, 0, 0, 5, 1};
    vecs[9]  = '{0, 0, 1, 1, 5, 1};
    vecs[10] = '{0, 1, 1, 0, 1, 2};
    vecs[11] = '{1, 0, 0, 1, 5, 1};
    vecs[12] = '{0, 1, 0, 0, 1, 1};
    vecs[13] = '{0, 1, 0, 0, 2, 1};
    vecs[14] = '{0, 1, 0, 0, 3, 1};
    vecs[15] = '{0, 0, 1, 0, 3, 2};
    vecs[16] = '{0, 0, 1, 0, 3, 3};
    vecs[17] = '{0, 0, 1, 0, 3, 4};

    reset = 1'b1;
    new_game = 1'b0;
    hit_in = 1'b0;
    apply_stimulus(0, 0, 0, 0, 0);
    #1 reset = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_state("reset");
    check_output("reset.confirm", 32'(confirm_attack), 1);
    check_output("reset.valid", 32'(shot_valid), 0);
    check_output("reset.hit", 32'(shot_hit), 0);
    check_output("reset.dup", 32'(dup_shot), 0);
    reset = 1'b1;
    tick();

    foreach (vecs[i]) begin
      op_move(vecs[i].l, vecs[i].r, vecs[i].u, vecs[i].d, $sformatf("vec%0d", i));
      check_output($sformatf("table%0d.x", i), 32'(x_coord_code), vecs[i].ex);
      check_output($sformatf("table%0d.y", i), 32'(y_coord_code), vecs[i].ey);
    end

    op_fire(0, 0, 0, 0, 1, "hit34");
    check_output("hit34.hits", 32'(hits_count), 1);
    check_output("hit34.shots", 32'(shots_left), 14);

    op_fire(0, 0, 0, 0, 1, "dup34");
    check_output("dup34.hits", 32'(hits_count), 1);
    check_output("dup34.shots", 32'(shots_left), 14);

    op_move(0, 0, 1, 0, "to35");
    op_fire(0, 1, 0, 0, 0, "firemove");
    check_output("firemove.x", 32'(x_coord_code), 3);
    check_output("firemove.y", 32'(y_coord_code), 5);

    // new_game in the middle of WAIT must abort the shot and clear the map.
    op_move(0, 0, 1, 0, "to36");
    apply_stimulus(0, 0, 0, 0, 1);
    hit_in = 1'b1;
    tick();
    check_output("ng.confirm_low", 32'(confirm_attack), 0);
    apply_stimulus(0, 0, 0, 0, 0);
    tick();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    model_reset();
    check_state("ng.wait");
    check_no_result("ng.wait", 5);
    op_fire(0, 0, 0, 0, 0, "ng.refire");

    op_new_game("ng2");
    apply_stimulus(0, 0, 0, 0, 1);
    tick();
    check_output("ar.confirm_low", 32'(confirm_attack), 0);
    apply_stimulus(0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_output("ar.confirm_async", 32'(confirm_attack), 1);
    check_output("ar.shots_async", 32'(shots_left), MAX_SHOTS);
    @(negedge clk);
    reset = 1'b1;
    check_no_result("ar", 5);
    check_state("ar");
    op_fire(0, 0, 0, 0, 0, "ar.refire");

    // Diagonal walk (x+1, y+1) visits distinct cells because 5 and 7 are coprime.
    op_new_game("loss");
    for (int i = 0; i < MAX_SHOTS; i++) begin
      op_fire(0, 0, 0, 0, 0, $sformatf("miss%0d", i));
      op_move(0, 1, 1, 0, $sformatf("miss_mv%0d", i));
    end
    check_output("loss.shots", 32'(shots_left), 0);
    check_output("loss.over", 32'(game_over), 1);
    check_output("loss.win", 32'(win), 0);
    op_fire(0, 0, 0, 0, 1, "loss.fire");
    op_move(1, 0, 1, 0, "loss.move");

    op_new_game("wingame");
    for (int i = 0; i < SHIP_CELLS; i++) begin
      op_fire(0, 0, 0, 0, 1, $sformatf("hit%0d", i));
      op_move(0, 1, 1, 0, $sformatf("hit_mv%0d", i));
    end
    check_output("win.hits", 32'(hits_count), 9);
    check_output("win.shots", 32'(shots_left), 6);
    check_output("win.over", 32'(game_over), 1);
    check_output("win.win", 32'(win), 1);
    op_fire(0, 0, 0, 0, 1, "win.fire");

    for (int g = 0; g < 3; g++) begin
      op_new_game($sformatf("rg%0d", g));
      for (int n = 0; n < 120 && !m_over; n++) begin
        int mask;
        mask = int'($urandom_range(0, 15));
        if ($urandom_range(0, 9) < 6) begin
          op_move(mask & 1, (mask >> 1) & 1, (mask >> 2) & 1, (mask >> 3) & 1, $sformatf("rg%0d.mv%0d", g, n));
        end else begin
          op_fire(mask & 1, (mask >> 1) & 1, (mask >> 2) & 1, (mask >> 3) & 1,
                  int'($urandom_range(0, 2) != 0), $sformatf("rg%0d.f%0d", g, n));
        end
      end
      op_move(0, 1, 0, 0, $sformatf("rg%0d.end_mv", g));
      op_fire(0, 0, 0, 0, 1, $sformatf("rg%0d.end_f", g));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
